// File: rtl/note_player.sv
// note_player: plays one note per accepted request as a square wave on buzzer.
// A request carries a note (0 = rest, 1..7 = C..B), an octave and a length in ms.
// The length is counted with a ms tick that restarts at acceptance.
// stop aborts the note; done pulses once on every return to IDLE.
// Build option: define NOTE_PLAYER_GAP_EN to follow every note with a silent
// GAP_MS gap before returning to IDLE. Without it the GAP state and its counter
// are not built.
module note_player #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int GAP_MS   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [2:0] note_idx,
  input  logic [1:0] octave,
  input  logic [7:0] duration_ms,
  input  logic       stop,
  output logic       buzzer,
  output logic       busy,
  output logic       done
);

  localparam int MS_CYC = CLK_FREQ / 1000;
  localparam int MS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  // 20 bits covers low C at 100 MHz (about 381k cycles per half-period).
  localparam int HP_W   = 20;

`ifdef NOTE_PLAYER_GAP_EN
  localparam int GAP_CYC = GAP_MS * MS_CYC;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
  typedef enum logic {IDLE, PLAY} state_t;
`endif

  state_t            state, state_nx;
  logic [2:0]        note_q;
  logic [1:0]        oct_q;
  logic [MS_W-1:0]   ms_cnt;
  logic [7:0]        ms_left;
  logic [HP_W-1:0]   half_cnt;
  logic [HP_W-1:0]   base_half, half_per;
  logic              accept, ms_tick, play_end;

  // Base half-period of each note in clk cycles, middle octave.
  function automatic logic [HP_W-1:0] note_half(input logic [2:0] idx);
    case (idx)
      3'd1:    note_half = HP_W'(CLK_FREQ / (2 * 262));
      3'd2:    note_half = HP_W'(CLK_FREQ / (2 * 294));
      3'd3:    note_half = HP_W'(CLK_FREQ / (2 * 330));
      3'd4:    note_half = HP_W'(CLK_FREQ / (2 * 349));
      3'd5:    note_half = HP_W'(CLK_FREQ / (2 * 392));
      3'd6:    note_half = HP_W'(CLK_FREQ / (2 * 440));
      3'd7:    note_half = HP_W'(CLK_FREQ / (2 * 494));
      default: note_half = '0;
    endcase
  endfunction

  assign note_ready = (state == IDLE) && !stop;
  assign busy       = (state != IDLE);
  assign accept     = note_valid && note_ready;
  assign ms_tick    = (ms_cnt == MS_W'(MS_CYC - 1));
  // A zero-length note still spends one cycle in PLAY.
  assign play_end   = (ms_left == 8'd0) || (ms_tick && (ms_left == 8'd1));

  // Half-period of the latched note after octave scaling.
  always_comb begin
    base_half = note_half(note_q);
    case (oct_q)
      2'd0:    half_per = {base_half[HP_W-2:0], 1'b0};
      2'd2:    half_per = base_half >> 1;
      default: half_per = base_half;
    endcase
  end

`ifdef NOTE_PLAYER_GAP_EN
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_end;

  assign gap_end = (gap_cnt == GAP_W'(GAP_CYC - 1));

  // Gap length counter, running only while in GAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              gap_cnt <= '0;
    else if (state == GAP)  gap_cnt <= gap_cnt + 1'b1;
    else                    gap_cnt <= '0;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment up front prevents a latch on untaken paths.
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = PLAY;
      PLAY: begin
        if (stop) state_nx = IDLE;
`ifdef NOTE_PLAYER_GAP_EN
        else if (play_end) state_nx = GAP;
`else
        else if (play_end) state_nx = IDLE;
`endif
      end
`ifdef NOTE_PLAYER_GAP_EN
      GAP: if (stop || gap_end) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, ms timing, tone generation and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_q   <= '0;
      oct_q    <= '0;
      ms_cnt   <= '0;
      ms_left  <= '0;
      half_cnt <= '0;
      buzzer   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state != IDLE) && (state_nx == IDLE);
      if (accept) begin
        note_q   <= note_idx;
        oct_q    <= octave;
        ms_left  <= duration_ms;
        ms_cnt   <= '0;
        half_cnt <= '0;
        buzzer   <= 1'b0;
      end else if (state == PLAY) begin
        ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
        if (ms_tick) ms_left <= ms_left - 1'b1;
        if (state_nx != PLAY) begin
          buzzer <= 1'b0;
        end else if (note_q != 3'd0) begin
          if (half_cnt == half_per - 1'b1) begin
            buzzer   <= ~buzzer;
            half_cnt <= '0;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: self-checking bench for note_player at 1 MHz with a 2 ms gap.
// Expected waveforms come from a cycle-indexed model: half-period from the note
// frequency, buzzer = (cycles since acceptance / half-period) mod 2 while playing.
`timescale 1ns/1ps
module tb_note_player;

  localparam int CLK_FREQ = 1_000_000;
  localparam int GAP_MS   = 2;
  localparam int MS       = CLK_FREQ / 1000;
`ifdef NOTE_PLAYER_GAP_EN
  localparam int G = GAP_MS * MS;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, note_valid, note_ready, stop, buzzer, busy, done;
  logic [2:0] note_idx;
  logic [1:0] octave;
  logic [7:0] duration_ms;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  note_player #(.CLK_FREQ(CLK_FREQ), .GAP_MS(GAP_MS)) dut (
    .clk        (clk),
    .reset      (reset),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_idx   (note_idx),
    .octave     (octave),
    .duration_ms(duration_ms),
    .stop       (stop),
    .buzzer     (buzzer),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Half-period in cycles for a note/octave pair.
  function automatic int model_hp(input int nt, input int oc);
    int f;
    int hp;
    case (nt)
      1: f = 262;
      2: f = 294;
      3: f = 330;
      4: f = 349;
      5: f = 392;
      6: f = 440;
      7: f = 494;
      default: f = 0;
    endcase
    if (f == 0) return 0;
    hp = CLK_FREQ / (2 * f);
    if (oc == 0)      hp = hp * 2;
    else if (oc == 2) hp = hp / 2;
    return hp;
  endfunction

  // Expected buzzer j cycles after acceptance; silent outside the tone window.
  function automatic logic model_bz(input int nt, input int oc, input int tone_len, input int j);
    int hp;
    hp = model_hp(nt, oc);
    if (nt == 0 || j >= tone_len) return 1'b0;
    return ((j / hp) % 2) == 1;
  endfunction

  // Plays one note from a post-edge sample point in IDLE and checks every cycle
  // up to and including the return to IDLE. stop_at < 0 means no abort.
  task automatic play_note(input int nt, input int oc, input int du, input int stop_at,
                           input string name, output int acc_cyc, output int exit_cyc);
    int hp, p, tot, tone_len, exp_tog, tog, first_tog;
    int bad_bz, bad_busy, bad_done, first_bz;
    logic got_bz, prev_bz, bz_e, busy_e, done_e;
    hp = model_hp(nt, oc);
    p = (du == 0) ? 1 : du * MS;
    tot = (stop_at >= 0) ? stop_at : p + G;
    tone_len = (p < tot) ? p : tot;
    exp_tog = (nt == 0) ? 0 : (tone_len - 1) / hp;
    bad_bz = 0; bad_busy = 0; bad_done = 0; first_bz = -1; got_bz = 1'b0;
    tog = 0; first_tog = -1; prev_bz = 1'b0; exit_cyc = -1;

    tests_run++;
    if (note_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready: got %b, required 1", name, note_ready);
    end
    note_valid = 1'b1;
    note_idx = 3'(nt);
    octave = 2'(oc);
    duration_ms = 8'(du);
    @(posedge clk); #1;
    acc_cyc = cyc;

    for (int j = 0; j <= tot; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      if (j == p) exit_cyc = cyc;
      bz_e = model_bz(nt, oc, tone_len, j);
      busy_e = (j < tot);
      done_e = (j == tot);
      if (buzzer !== bz_e) begin
        if (bad_bz == 0) begin first_bz = j; got_bz = buzzer; end
        bad_bz++;
      end
      if (busy !== busy_e) bad_busy++;
      if (done !== done_e) bad_done++;
      if (j >= 1 && j < tone_len && buzzer !== prev_bz) begin
        tog++;
        if (first_tog < 0) first_tog = j;
      end
      prev_bz = buzzer;
      // Inputs other than stop wander while busy; only the latched copy matters.
      if (j < tot) begin
        note_valid = 1'($urandom_range(0, 1));
        note_idx = 3'($urandom_range(0, 7));
        octave = 2'($urandom_range(0, 3));
        duration_ms = 8'($urandom_range(0, 255));
      end else begin
        note_valid = 1'b0;
      end
      if (stop_at >= 0 && j == stop_at - 1) stop = 1'b1;
      if (stop_at >= 0 && j == stop_at) stop = 1'b0;
    end

    tests_run++;
    if (bad_bz != 0) begin
      tests_failed++;
      $display("FAIL %s buzzer: %0d wrong cycles, first at %0d got %b, required %b",
               name, bad_bz, first_bz, got_bz, ~got_bz);
    end
    tests_run++;
    if (bad_busy != 0) begin
      tests_failed++;
      $display("FAIL %s busy: %0d wrong cycles, required busy for %0d cycles", name, bad_busy, tot);
    end
    tests_run++;
    if (bad_done != 0) begin
      tests_failed++;
      $display("FAIL %s done: %0d wrong cycles, required one pulse at cycle %0d", name, bad_done, tot);
    end
    tests_run++;
    if (tog != exp_tog) begin
      tests_failed++;
      $display("FAIL %s toggles: got %0d, required %0d", name, tog, exp_tog);
    end
    if (exp_tog > 0) begin
      tests_run++;
      if (first_tog != hp) begin
        tests_failed++;
        $display("FAIL %s half_period: first toggle at %0d, required %0d", name, first_tog, hp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({buzzer, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_outputs: buzzer/busy/done got %b, required 000", {buzzer, busy, done});
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (note_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b, required 1", note_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tones();
    int a, e;
    play_note(6, 1, 3, -1, "note_a_mid", a, e);
    play_note(1, 0, 1, -1, "note_c_low", a, e);
    play_note(1, 2, 1, -1, "note_c_high", a, e);
    play_note(1, 3, 1, -1, "note_c_oct3", a, e);
  endtask

  task automatic test_rest_and_zero();
    int a, e;
    play_note(0, 1, 2, -1, "rest_2ms", a, e);
    play_note(4, 1, 0, -1, "zero_duration", a, e);
  endtask

  task automatic test_stop();
    int a, e;
    play_note(7, 2, 3, 500, "stop_in_play", a, e);
`ifdef NOTE_PLAYER_GAP_EN
    play_note(2, 1, 1, MS + 100, "stop_in_gap", a, e);
`endif
    // stop together with valid in IDLE must block acceptance.
    stop = 1'b1;
    note_valid = 1'b1;
    note_idx = 3'd5;
    duration_ms = 8'd1;
    #1;
    tests_run++;
    if (note_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_idle_ready: got %b, required 0", note_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL stop_idle_accept: busy/done got %b, required 00", {busy, done});
    end
    stop = 1'b0;
    note_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset_midnote();
    int dn;
    tests_run++;
    if (note_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_ready: got %b, required 1", note_ready);
    end
    note_valid = 1'b1;
    note_idx = 3'd6;
    octave = 2'd1;
    duration_ms = 8'd3;
    @(posedge clk); #1;
    note_valid = 1'b0;
    repeat (1499) @(posedge clk);
    #1;
    tests_run++;
    if (buzzer !== model_bz(6, 1, 3 * MS, 1499)) begin
      tests_failed++;
      $display("FAIL reset_mid_pre: buzzer got %b, required %b", buzzer, model_bz(6, 1, 3 * MS, 1499));
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({buzzer, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_mid_async: buzzer/busy/done got %b, required 000", {buzzer, busy, done});
    end
    dn = 0;
    repeat (3) begin @(posedge clk); #1; dn += int'(done); end
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; dn += int'(done); end
    tests_run++;
    if (dn != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_done: got %0d pulses, required 0", dn);
    end
    tests_run++;
    if ({note_ready, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_mid_idle: ready/busy got %b, required 10", {note_ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    int acc_a, exit_a, acc_b, exit_b;
    play_note(3, 1, 1, -1, "b2b_first", acc_a, exit_a);
    play_note(5, 2, 1, -1, "b2b_second", acc_b, exit_b);
    tests_run++;
    if (acc_b - exit_a - 1 != G) begin
      tests_failed++;
      $display("FAIL b2b_silence: got %0d silent cycles, required %0d", acc_b - exit_a - 1, G);
    end
  endtask

  task automatic test_random();
    int a, e;
    for (int i = 0; i < 6; i++) begin
      play_note(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), -1, "random", a, e);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL final_idle: busy/done got %b, required 00", {busy, done});
    end
  endtask

  initial begin
    reset = 1'b1;
    note_valid = 1'b0;
    stop = 1'b0;
    note_idx = 3'd0;
    octave = 2'd0;
    duration_ms = 8'd0;
    test_reset();
    test_tones();
    test_rest_and_zero();
    test_stop();
    test_reset_midnote();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
